gbe_tx_packetizer: RTL and testbench

Streaming packetizer between the DSP output and the 10GbE transmit core, in the `user_clk` domain. Consumes the software-written destination-port word from the `gbe_sw_port` register (`user_data_out`) and applies it only at packet boundaries. Frames a continuous 64-bit data stream into packets of one header word plus `PAYLOAD_LEN` payload words, with end-of-frame marking. Drops whole packets when transmit is disabled or the core reports almost-full.

---
 rtl/gbe_tx_pkg.sv | 17 +
 rtl/sw_reg_stabilizer.sv | 51 +++++
 rtl/gbe_tx_packetizer.sv | 194 +++++++++++++++++++
 tb/tb_gbe_tx_packetizer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gbe_tx_pkg.sv
// Shared definitions for the 10GbE transmit packetizer: header layout,
// software register bit positions and the framing state encoding.
package gbe_tx_pkg;

    localparam int unsigned MCNT_LSB = 0;
    localparam int unsigned MCNT_W   = 48;

    localparam int unsigned EN_BIT   = 31;
    localparam int unsigned PORT_MSB = 15;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DROP
    } tx_state_e;

endpackage : gbe_tx_pkg

// File: rtl/sw_reg_stabilizer.sv
// Compare-and-commit shadow for a software register: a value is committed only
// after COUNT consecutive identical samples.
module sw_reg_stabilizer #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      COUNT     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned      CNT_W   = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_d is the length of the identical-sample run including this cycle.
    always_comb begin
        prev_d   = din;
        shadow_d = shadow_q;
        if (din != prev_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_d == CNT_MAX) begin
            shadow_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= RESET_VAL;
            shadow_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = shadow_q;

endmodule : sw_reg_stabilizer

// File: rtl/gbe_tx_packetizer.sv
// Frames a continuous 64-bit stream into header + PAYLOAD_LEN word packets for
// the 10GbE core, dropping whole packets when disabled, almost-full or gapless.
module gbe_tx_packetizer
    import gbe_tx_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN   = 128,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [15:0] DEFAULT_PORT  = 16'd60000
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] sw_port_reg,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    input  logic        in_sync,
    input  logic        tx_afull,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    output logic        tx_eof,
    output logic [15:0] tx_dest_port,
    output logic [15:0] drop_cnt,
    output logic        err_gap
);

    localparam int unsigned       WIDX_W    = $clog2(PAYLOAD_LEN);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(PAYLOAD_LEN - 1);
    localparam int unsigned       SHADOW_W  = PORT_MSB + 2;

    logic [SHADOW_W-1:0] shadow;
    logic                shadow_en;
    logic [PORT_MSB:0]   shadow_port;
    logic                unused_sw_bits;

    assign unused_sw_bits = ^sw_port_reg[EN_BIT-1:PORT_MSB+1];

    sw_reg_stabilizer #(
        .WIDTH     (SHADOW_W),
        .COUNT     (STABLE_CYCLES),
        .RESET_VAL ({1'b0, DEFAULT_PORT})
    ) u_port_stab (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .din   ({sw_port_reg[EN_BIT], sw_port_reg[PORT_MSB:0]}),
        .dout  (shadow)
    );

    assign shadow_en   = shadow[SHADOW_W-1];
    assign shadow_port = shadow[PORT_MSB:0];

    tx_state_e         state_q, state_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic              sync_pend_q, sync_pend_d;
    logic              last_q, last_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q, s1_last_d;
    logic [63:0]       s1_data_q, s1_data_d;
    logic [63:0]       tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_eof_q, tx_eof_d;
    logic [15:0]       dest_port_q, dest_port_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              err_gap_q, err_gap_d;

    logic              sync_now;
    logic              start;
    logic              gap_viol;
    logic              accept;
    logic              last_word;
    logic [MCNT_W-1:0] mcnt_cur;
    logic [63:0]       header;

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        mcnt_d      = mcnt_q;
        dest_port_d = dest_port_q;
        drop_cnt_d  = drop_cnt_q;
        err_gap_d   = err_gap_q;
        tx_data_d   = tx_data_q;

        // A pending resync is applied before any packet start in the same cycle.
        sync_now    = (state_q == IDLE) && (widx_q == '0) && (sync_pend_q || in_sync);
        sync_pend_d = sync_now ? 1'b0 : (sync_pend_q || in_sync);
        mcnt_cur    = sync_now ? '0 : mcnt_q;
        if (sync_now) begin
            mcnt_d = '0;
        end

        header = '0;
        header[MCNT_LSB +: MCNT_W] = mcnt_cur;

        last_word = in_valid && (widx_q == WIDX_LAST);
        gap_viol  = in_valid && last_q;
        start     = in_valid && (state_q == IDLE) && (widx_q == '0);
        accept    = start && shadow_en && !tx_afull && !gap_viol;
        last_d    = last_word;

        if (in_valid) begin
            widx_d = widx_q + WIDX_W'(1);
        end
        if (gap_viol) begin
            err_gap_d = 1'b1;
        end

        s1_valid_d = 1'b0;
        s1_last_d  = last_word;
        s1_data_d  = in_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcnt_d = mcnt_cur + MCNT_W'(1);
                    if (accept) begin
                        state_d     = SEND;
                        dest_port_d = shadow_port;
                        s1_valid_d  = 1'b1;
                    end else begin
                        state_d = DROP;
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end
                end
            end
            SEND: begin
                if (in_valid) begin
                    s1_valid_d = 1'b1;
                    if (last_word) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The header never collides with a buffered word: the mandatory gap
        // drains stage 1 one cycle before any accepted start.
        tx_valid_d = accept || s1_valid_q;
        tx_eof_d   = !accept && s1_valid_q && s1_last_q;
        if (accept) begin
            tx_data_d = header;
        end else if (s1_valid_q) begin
            tx_data_d = s1_data_q;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= IDLE;
            widx_q      <= '0;
            mcnt_q      <= '0;
            sync_pend_q <= 1'b0;
            last_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_data_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_eof_q    <= 1'b0;
            dest_port_q <= DEFAULT_PORT;
            drop_cnt_q  <= '0;
            err_gap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            mcnt_q      <= mcnt_d;
            sync_pend_q <= sync_pend_d;
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_data_q   <= s1_data_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_eof_q    <= tx_eof_d;
            dest_port_q <= dest_port_d;
            drop_cnt_q  <= drop_cnt_d;
            err_gap_q   <= err_gap_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign tx_eof       = tx_eof_q;
    assign tx_dest_port = dest_port_q;
    assign drop_cnt     = drop_cnt_q;
    assign err_gap      = err_gap_q;

endmodule : gbe_tx_packetizer

// File: tb/tb_gbe_tx_packetizer.sv
// Scoreboard bench for gbe_tx_packetizer with PAYLOAD_LEN=4, STABLE_CYCLES=4.
module tb_gbe_tx_packetizer;

    localparam logic [15:0] DEF_PORT = 16'd60000;

    logic        user_clk;
    logic        user_rst_n;
    logic [31:0] sw_port_reg;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_sync;
    logic        tx_afull;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_eof;
    logic [15:0] tx_dest_port;
    logic [15:0] drop_cnt;
    logic        err_gap;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        eof;
        logic [15:0] port;
    } exp_t;

    exp_t sb_q[$];

    gbe_tx_packetizer #(
        .PAYLOAD_LEN   (4),
        .STABLE_CYCLES (4),
        .DEFAULT_PORT  (DEF_PORT)
    ) dut (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .sw_port_reg  (sw_port_reg),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_sync      (in_sync),
        .tx_afull     (tx_afull),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_eof       (tx_eof),
        .tx_dest_port (tx_dest_port),
        .drop_cnt     (drop_cnt),
        .err_gap      (err_gap)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge user_clk) begin
        exp_t e;
        if (user_rst_n) begin
            if (tx_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_valid", 64'(tx_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("tx_data", tx_data, e.data);
                    check_val("tx_eof", 64'(tx_eof), 64'(e.eof));
                    check_val("tx_dest_port", 64'(tx_dest_port), 64'(e.port));
                end
            end else begin
                check_val("eof_without_valid", 64'(tx_eof), 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge user_clk);
        #1;
    endtask

    task automatic word(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
        in_sync  = 1'b0;
        tx_afull = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    function automatic logic [63:0] pw(input int pkt, input int k);
        return 64'hA5A5_0000_0000_0000 | (64'(pkt) << 8) | 64'(k);
    endfunction

    task automatic push(input logic [63:0] d, input logic eof, input logic [15:0] port);
        exp_t e;
        e.data = d;
        e.eof  = eof;
        e.port = port;
        sb_q.push_back(e);
    endtask

    task automatic expect_pkt(input int pkt, input logic [47:0] mcnt, input logic [15:0] port);
        push({16'h0000, mcnt}, 1'b0, port);
        for (int k = 0; k < 4; k++) push(pw(pkt, k), (k == 3), port);
    endtask

    task automatic send_pkt(input int pkt);
        for (int k = 0; k < 4; k++) word(pw(pkt, k));
    endtask

    task automatic check_resets(input string tag);
        check_val({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check_val({tag, "_tx_eof"}, 64'(tx_eof), 64'd0);
        check_val({tag, "_err_gap"}, 64'(err_gap), 64'd0);
        check_val({tag, "_tx_data"}, tx_data, 64'd0);
        check_val({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        check_val({tag, "_dest_port"}, 64'(tx_dest_port), 64'(DEF_PORT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        user_rst_n  = 1'b0;
        sw_port_reg = 32'h8000_EA60;
        in_data     = '0;
        in_valid    = 1'b0;
        in_sync     = 1'b0;
        tx_afull    = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        check_resets("reset");
        user_rst_n = 1'b1;
        idle(6);

        for (int i = 0; i < 10; i++) begin
            sw_port_reg = (i % 2 == 0) ? 32'h0000_1111 : 32'h8000_2222;
            cyc();
        end
        sw_port_reg = 32'h8000_EA60;
        check_val("glitch_dest_port", 64'(tx_dest_port), 64'(DEF_PORT));

        // P0: port write lands during the frame, frame keeps old port.
        expect_pkt(0, 48'd0, 16'hEA60);
        word(pw(0, 0));
        sw_port_reg = 32'h8000_1234;
        word(pw(0, 1));
        word(pw(0, 2));
        word(pw(0, 3));
        idle(1);
        // P1 first word is exactly STABLE_CYCLES after the write.
        expect_pkt(1, 48'd1, 16'h1234);
        send_pkt(1);
        idle(1);

        tx_afull = 1'b1;
        send_pkt(2);
        idle(1);
        check_val("drop_afull", 64'(drop_cnt), 64'd1);
        expect_pkt(3, 48'd3, 16'h1234);
        send_pkt(3);
        idle(1);

        sw_port_reg = 32'h0000_1234;
        idle(5);
        send_pkt(4);
        idle(1);
        check_val("drop_disabled", 64'(drop_cnt), 64'd2);
        sw_port_reg = 32'h8000_1234;
        idle(5);
        expect_pkt(5, 48'd5, 16'h1234);
        send_pkt(5);
        idle(1);

        // New value seen for only STABLE_CYCLES-1 cycles before P6 starts.
        sw_port_reg = 32'h8000_5678;
        idle(3);
        expect_pkt(6, 48'd6, 16'h1234);
        send_pkt(6);
        idle(1);
        expect_pkt(7, 48'd7, 16'h5678);
        send_pkt(7);
        idle(1);

        expect_pkt(8, 48'd8, 16'h5678);
        send_pkt(8);
        check_val("err_gap_before", 64'(err_gap), 64'd0);
        send_pkt(9);
        idle(1);
        check_val("err_gap_set", 64'(err_gap), 64'd1);
        check_val("drop_gap", 64'(drop_cnt), 64'd3);

        expect_pkt(10, 48'd10, 16'h5678);
        word(pw(10, 0));
        idle(2);
        word(pw(10, 1));
        word(pw(10, 2));
        idle(1);
        word(pw(10, 3));
        idle(1);

        expect_pkt(11, 48'd11, 16'h5678);
        word(pw(11, 0));
        word(pw(11, 1));
        in_sync = 1'b1;
        word(pw(11, 2));
        word(pw(11, 3));
        idle(1);
        expect_pkt(12, 48'd0, 16'h5678);
        send_pkt(12);
        idle(1);
        expect_pkt(13, 48'd0, 16'h5678);
        in_sync = 1'b1;
        send_pkt(13);
        idle(1);
        expect_pkt(14, 48'd1, 16'h5678);
        word(pw(14, 0));
        tx_afull = 1'b1;
        word(pw(14, 1));
        word(pw(14, 2));
        word(pw(14, 3));
        idle(4);
        check_val("err_gap_sticky", 64'(err_gap), 64'd1);
        check_val("drop_final", 64'(drop_cnt), 64'd3);
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);

        // Reset mid-frame: only the header escapes before the abort.
        push({16'h0000, 48'd2}, 1'b0, 16'h5678);
        word(pw(15, 0));
        word(pw(15, 1));
        user_rst_n = 1'b0;
        idle(2);
        check_resets("midreset");
        user_rst_n = 1'b1;
        idle(6);
        expect_pkt(16, 48'd0, 16'h5678);
        send_pkt(16);
        idle(4);
        check_val("post_reset_drop", 64'(drop_cnt), 64'd0);
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gbe_tx_packetizer
